// File: rtl/sprite_pkg.sv
// Shared types and helpers for the multi-sprite address generator.
// Optional feature macro: SPRITE_MIRROR_EN (adds a per-sprite horizontal mirror bit).
package sprite_pkg;

  // Storage width for sprite coordinates; instances use the low COORD_W bits.
  localparam int COORD_W_MAX = 16;

  // Default sprite dimensions and the address fields they imply.
  localparam int SPR_W_DEF = 64;
  localparam int SPR_H_DEF = 64;

  // Address/index width helper: never returns less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DX_W_DEF   = clog2_min1(SPR_W_DEF);
  localparam int DY_W_DEF   = clog2_min1(SPR_H_DEF);
  localparam int ADDR_W_DEF = DX_W_DEF + DY_W_DEF;

  typedef struct packed {
    logic [COORD_W_MAX-1:0] x;
    logic [COORD_W_MAX-1:0] y;
    logic                   en;
`ifdef SPRITE_MIRROR_EN
    logic                   mirror;
`endif
  } spr_pos_t;

  localparam spr_pos_t SPR_POS_ZERO = {$bits(spr_pos_t){1'b0}};

endpackage

// File: rtl/sprite_hit_test.sv
// Per-sprite box test: subtracts the sprite corner from the pixel (mod 2^COORD_W),
// checks the offsets against the sprite size and registers hit plus offset LSBs.
// With SPRITE_MIRROR_EN defined, the registered dx field is already mirrored.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter  int COORD_W = 10,
  parameter  int SPR_W   = 64,
  parameter  int SPR_H   = 64,
  localparam int DX_W    = clog2_min1(SPR_W),
  localparam int DY_W    = clog2_min1(SPR_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixelx,
  input  logic [COORD_W-1:0] pixely,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               en,
`ifdef SPRITE_MIRROR_EN
  input  logic               mirror,
`endif
  output logic               hit_r,
  output logic [DX_W-1:0]    dx_r,
  output logic [DY_W-1:0]    dy_r
);

  logic [COORD_W-1:0] dx_s;
  logic [COORD_W-1:0] dy_s;
  logic               in_range_s;
  logic [DX_W-1:0]    dx_field_s;

  // Modular offsets; a pixel left of/above the corner wraps to a large value and misses.
  always_comb begin
    dx_s       = pixelx - pos_x;
    dy_s       = pixely - pos_y;
    in_range_s = en && (int'(dx_s) < SPR_W) && (int'(dy_s) < SPR_H);
`ifdef SPRITE_MIRROR_EN
    // SPR_W is a power of two, so (SPR_W-1)-dx is the bitwise complement of dx.
    if (mirror) begin
      dx_field_s = ~dx_s[DX_W-1:0];
    end else begin
      dx_field_s = dx_s[DX_W-1:0];
    end
`else
    dx_field_s = dx_s[DX_W-1:0];
`endif
  end

  // Stage-1 register for this sprite's hit flag and offsets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r <= 1'b0;
      dx_r  <= {DX_W{1'b0}};
      dy_r  <= {DY_W{1'b0}};
    end else begin
      hit_r <= in_range_s;
      dx_r  <= dx_field_s;
      dy_r  <= dy_s[DY_W-1:0];
    end
  end

endmodule

// File: rtl/sprite_addr_gen.sv
// Multi-sprite ROM address generator: shadow/active position banks committed at
// frame_start, per-sprite hit test (stage 1), fixed-priority select (stage 2).
// Optional feature macro: SPRITE_MIRROR_EN (input pos_mirror, mirrored dx field).
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter  int COORD_W = 10,
  parameter  int SPR_W   = SPR_W_DEF,
  parameter  int SPR_H   = SPR_H_DEF,
  parameter  int NUM_SPR = 4,
  localparam int IDX_W   = clog2_min1(NUM_SPR),
  localparam int DX_W    = clog2_min1(SPR_W),
  localparam int DY_W    = clog2_min1(SPR_H),
  localparam int ADDR_W  = DX_W + DY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pos_we,
  input  logic [IDX_W-1:0]   pos_idx,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_en,
`ifdef SPRITE_MIRROR_EN
  input  logic               pos_mirror,
`endif
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pixelx,
  input  logic [COORD_W-1:0] pixely,
  output logic               out_valid,
  output logic               hit,
  output logic [IDX_W-1:0]   spr_id,
  output logic [ADDR_W-1:0]  address
);

  spr_pos_t          shadow_r     [NUM_SPR];
  spr_pos_t          active_r     [NUM_SPR];
  spr_pos_t          shadow_nxt_s [NUM_SPR];
  spr_pos_t          wr_pos_s;

  logic [NUM_SPR-1:0] in_s;
  logic [DX_W-1:0]    dx_s [NUM_SPR];
  logic [DY_W-1:0]    dy_s [NUM_SPR];
  logic               v1_r;

  logic               hit_s;
  logic [IDX_W-1:0]   win_s;
  logic [ADDR_W-1:0]  addr_s;

  logic               out_valid_r;
  logic               hit_r;
  logic [IDX_W-1:0]   spr_id_r;
  logic [ADDR_W-1:0]  address_r;

  // Shadow bank after this cycle's write, so a same-cycle commit sees the new value.
  always_comb begin
    wr_pos_s        = SPR_POS_ZERO;
    wr_pos_s.x      = COORD_W_MAX'(pos_x);
    wr_pos_s.y      = COORD_W_MAX'(pos_y);
    wr_pos_s.en     = pos_en;
`ifdef SPRITE_MIRROR_EN
    wr_pos_s.mirror = pos_mirror;
`endif
    shadow_nxt_s = shadow_r;
    if (pos_we && (int'(pos_idx) < NUM_SPR)) begin
      shadow_nxt_s[pos_idx] = wr_pos_s;
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Shadow bank tracks writes; active bank is refreshed only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_r[i] <= SPR_POS_ZERO;
        active_r[i] <= SPR_POS_ZERO;
      end
    end else begin
      shadow_r <= shadow_nxt_s;
      if (frame_start) begin
        active_r <= shadow_nxt_s;
      end
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    sprite_hit_test #(
      .COORD_W (COORD_W),
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H)
    ) u_hit (
      .clk    (clk),
      .rst_n  (rst_n),
      .pixelx (pixelx),
      .pixely (pixely),
      .pos_x  (active_r[g].x[COORD_W-1:0]),
      .pos_y  (active_r[g].y[COORD_W-1:0]),
      .en     (active_r[g].en),
`ifdef SPRITE_MIRROR_EN
      .mirror (active_r[g].mirror),
`endif
      .hit_r  (in_s[g]),
      .dx_r   (dx_s[g]),
      .dy_r   (dy_s[g])
    );
  end

  // Stage-1 valid travels alongside the per-sprite registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= pix_valid;
    end
  end

  // Fixed-priority select: scanning downward lets the lowest hitting index win.
  always_comb begin
    hit_s  = |in_s;
    win_s  = {IDX_W{1'b0}};
    addr_s = {ADDR_W{1'b0}};
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      win_s  = in_s[i] ? IDX_W'(i) : win_s;
      addr_s = in_s[i] ? {dy_s[i], dx_s[i]} : addr_s;
    end
  end

  // Stage-2 output register; bubbles and misses present all-zero results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      hit_r       <= 1'b0;
      spr_id_r    <= {IDX_W{1'b0}};
      address_r   <= {ADDR_W{1'b0}};
    end else begin
      out_valid_r <= v1_r;
      hit_r       <= v1_r & hit_s;
      spr_id_r    <= (v1_r & hit_s) ? win_s  : {IDX_W{1'b0}};
      address_r   <= (v1_r & hit_s) ? addr_s : {ADDR_W{1'b0}};
    end
  end

  assign out_valid = out_valid_r;
  assign hit       = hit_r;
  assign spr_id    = spr_id_r;
  assign address   = address_r;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Scoreboard bench for sprite_addr_gen: directed scenarios plus random traffic,
// expectations from a box-membership model of the sprite banks.
module tb_sprite_addr_gen;

  localparam int CW = 10;
  localparam int SW = 64;
  localparam int SH = 64;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int AW = 12;
  localparam int CMASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          pos_we;
  logic [IW-1:0] pos_idx;
  logic [CW-1:0] pos_x, pos_y;
  logic          pos_en;
  logic          pos_mirror;
  logic          pix_valid;
  logic [CW-1:0] pixelx, pixely;
  logic          out_valid, hit;
  logic [IW-1:0] spr_id;
  logic [AW-1:0] address;

  always #5 clk = ~clk;

  sprite_addr_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pos_we      (pos_we),
    .pos_idx     (pos_idx),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_en      (pos_en),
`ifdef SPRITE_MIRROR_EN
    .pos_mirror  (pos_mirror),
`endif
    .pix_valid   (pix_valid),
    .pixelx      (pixelx),
    .pixely      (pixely),
    .out_valid   (out_valid),
    .hit         (hit),
    .spr_id      (spr_id),
    .address     (address)
  );

  typedef struct {
    bit hit;
    int id;
    int addr;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int   sh_x[NS], sh_y[NS], ac_x[NS], ac_y[NS];
  bit   sh_en[NS], sh_mir[NS], ac_en[NS], ac_mir[NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_pixel(input int px, input int py);
    exp_t e;
    e.hit = 1'b0; e.id = 0; e.addr = 0; e.cyc = 0;
    for (int i = 0; i < NS; i++) begin
      int dx, dy;
      dx = (px - ac_x[i]) & CMASK;
      dy = (py - ac_y[i]) & CMASK;
      if (!e.hit && ac_en[i] && dx < SW && dy < SH) begin
        e.hit = 1'b1;
        e.id  = i;
        if (ac_mir[i]) dx = SW - 1 - dx;
        e.addr = dy * SW + dx;
      end
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; sh_mir[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0; ac_mir[i] = 0;
    end
  endtask

  // One cycle of stimulus, applied on the falling edge; the model follows.
  task automatic drive(input bit we, input int idx, input int x, input int y, input bit en,
                       input bit mir, input bit fs, input bit pv, input int px, input int py);
    exp_t e;
    @(negedge clk);
    pos_we = we; pos_idx = idx[IW-1:0]; pos_x = x[CW-1:0]; pos_y = y[CW-1:0];
    pos_en = en; pos_mirror = mir; frame_start = fs;
    pix_valid = pv; pixelx = px[CW-1:0]; pixely = py[CW-1:0];
    if (rst_n) begin
      if (pv) begin
        e = model_pixel(px & CMASK, py & CMASK);
        e.cyc = cyc + 2;
        q.push_back(e);
      end
      if (we && idx < NS) begin
        sh_x[idx] = x & CMASK; sh_y[idx] = y & CMASK; sh_en[idx] = en;
`ifdef SPRITE_MIRROR_EN
        sh_mir[idx] = mir;
`else
        sh_mir[idx] = 1'b0;
`endif
      end
      if (fs) begin
        for (int i = 0; i < NS; i++) begin
          ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i]; ac_mir[i] = sh_mir[i];
        end
      end
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input bit en, input bit fs);
    drive(1'b1, idx, x, y, en, 1'b0, fs, 1'b0, 0, 0);
  endtask

  task automatic pix(input int px, input int py);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, px, py);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: pops one expectation per valid output, checks bubbles are all-zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency_cycle", cyc, e.cyc);
          chk("hit", {31'd0, hit}, {31'd0, e.hit});
          chk("spr_id", {30'd0, spr_id}, e.id);
          chk("address", {20'd0, address}, e.addr);
        end
      end else begin
        chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_hit", {31'd0, hit}, 32'd0);
        chk("bubble_spr_id", {30'd0, spr_id}, 32'd0);
        chk("bubble_address", {20'd0, address}, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pos_we = 1'b0; pos_idx = '0; pos_x = '0; pos_y = '0;
    pos_en = 1'b0; pos_mirror = 1'b0; pix_valid = 1'b0; pixelx = '0; pixely = '0;
    clear_model();
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_hit", {31'd0, hit}, 32'd0);
    chk("reset_spr_id", {30'd0, spr_id}, 32'd0);
    chk("reset_address", {20'd0, address}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single sprite and box edges (110,60 -> 0x28A; 163,113 -> 0xFFF).
    wr(0, 100, 50, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix(110, 60); pix(99, 60); pix(164, 60); pix(163, 113); pix(100, 50); pix(110, 49);
    idle(3);

    // Overlap: sprite0 beats sprite2, then sprite2 alone after disabling sprite0.
    wr(0, 0, 0, 1'b1, 1'b0);
    wr(2, 10, 10, 1'b1, 1'b1);
    pix(20, 20);
    wr(0, 0, 0, 1'b0, 1'b1);
    pix(20, 20);
    idle(3);

    // Deferred commit: rewritten position is invisible until frame_start.
    wr(0, 100, 50, 1'b1, 1'b1);
    pix(110, 60);
    wr(0, 200, 200, 1'b1, 1'b0);
    pix(110, 60);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix(110, 60); pix(210, 210);

    // Write, commit and pixel in one cycle: the pixel sees the old bank, the next the new.
    drive(1'b1, 1, 300, 300, 1'b1, 1'b0, 1'b1, 1'b1, 310, 310);
    pix(310, 310);

    // Sprite straddling the coordinate wrap, and a mirrored sprite.
    wr(3, 1000, 1000, 1'b1, 1'b1);
    pix(5, 5); pix(1010, 3); pix(40, 40);
    drive(1'b1, 1, 500, 500, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    pix(503, 507); pix(563, 500);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      bit we, en, mir, fs, pv;
      int idx, x, y, px, py;
      we  = ($urandom_range(0, 3) == 0);
      idx = $urandom_range(0, NS - 1);
      x   = ($urandom_range(0, 9) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 320);
      y   = ($urandom_range(0, 9) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 320);
      en  = ($urandom_range(0, 3) != 0);
      mir = $urandom_range(0, 1);
      fs  = ($urandom_range(0, 11) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      px  = $urandom_range(0, 390);
      py  = $urandom_range(0, 390);
      drive(we, idx, x, y, en, mir, fs, pv, px, py);
    end
    idle(3);

    // Reset while pixels stream through hitting sprites.
    wr(0, 100, 50, 1'b1, 1'b1);
    pix(110, 60); pix(120, 70); pix(130, 80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_hit", {31'd0, hit}, 32'd0);
    chk("midreset_address", {20'd0, address}, 32'd0);
    q.delete();
    clear_model();
    pix(110, 60); pix(111, 61);
    @(negedge clk);
    pix_valid = 1'b0; pos_we = 1'b0; frame_start = 1'b0;
    rst_n = 1'b1;
    pix(110, 60); pix(120, 70);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix(110, 60);
    wr(0, 100, 50, 1'b1, 1'b1);
    pix(110, 60); pix(163, 113);
    idle(4);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
